// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state encoding and constants for the memory bus sequencer
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROM  = 2'd1,
      EXT  = 2'd2,
      DONE = 2'd3
   } bus_st_e;

   localparam int          ROM_PAGE_W = 8;
   localparam logic [7:0]  RDATA_TMO  = 8'hFF;
   localparam logic [15:0] RESET_VEC  = 16'hFFFE;

   function automatic logic rom_page_hit(input logic [15:0] a, input logic [15:0] base);
      return a[15:ROM_PAGE_W] == base[15:ROM_PAGE_W];
   endfunction

endpackage

// File: rtl/bus_wait_cnt.sv
// rtl/bus_wait_cnt.sv - loadable 4-bit down-counter with zero flag, saturating at zero
module bus_wait_cnt (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic       zero
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_bus_seq.sv
// rtl/mem_bus_seq.sv - CPU bus-cycle sequencer for the stub ROM page and the external async port
module mem_bus_seq
   import mem_bus_pkg::*;
#(
   parameter logic [15:0] ROM_BASE = 16'hFF00,
   parameter int          ROM_WAIT = 1,
   parameter int          EXT_WAIT = 2,
   parameter int          EXT_TMO  = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req,
   input  logic [15:0]           addr,
   input  logic                  we,
   input  logic [7:0]            wdata,
   output logic                  ack,
   output logic [7:0]            rdata,
   output logic                  err,
   output logic                  rom_sel,
   output logic [ROM_PAGE_W-1:0] rom_a,
   input  logic [7:0]            rom_dout,
   output logic                  ext_sel,
   output logic [15:0]           ext_a,
   output logic                  ext_we,
   output logic [7:0]            ext_din,
   input  logic [7:0]            ext_dout,
   input  logic                  ext_rdy
);

   localparam logic [7:0] TMO_LAST = 8'(EXT_TMO - 1);

   bus_st_e state, state_nxt;

   logic [3:0]            cnt;
   logic                  cnt_zero;
   logic                  cnt_load;
   logic [3:0]            cnt_val;
   logic                  cnt_dec;
   logic [7:0]            tmo, tmo_d;
   logic                  rom_hit;
   logic                  rom_last;
   logic                  tmo_hit;

   logic                  ack_d, err_d, rom_sel_d, ext_sel_d, ext_we_d;
   logic [7:0]            rdata_d, ext_din_d;
   logic [ROM_PAGE_W-1:0] rom_a_d;
   logic [15:0]           ext_a_d;

   bus_wait_cnt u_wait (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   assign rom_hit  = rom_page_hit(addr, ROM_BASE);
   assign rom_last = (cnt == 4'd1);
   assign tmo_hit  = (tmo == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req) state_nxt = rom_hit ? (we ? DONE : ROM) : EXT;
         ROM:  if (rom_last) state_nxt = DONE;
         // ext_rdy only counts once the minimum wait phase has drained
         EXT:  if (cnt_zero && (ext_rdy || tmo_hit)) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ack_d     = 1'b0;
      err_d     = err;
      rdata_d   = rdata;
      rom_sel_d = rom_sel;
      rom_a_d   = rom_a;
      ext_sel_d = ext_sel;
      ext_a_d   = ext_a;
      ext_we_d  = ext_we;
      ext_din_d = ext_din;
      tmo_d     = tmo;
      cnt_load  = 1'b0;
      cnt_val   = 4'd0;
      cnt_dec   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               err_d = 1'b0;
               tmo_d = 8'd0;
               if (rom_hit && we) begin
                  err_d = 1'b1;
                  ack_d = 1'b1;
               end else if (rom_hit) begin
                  rom_sel_d = 1'b1;
                  rom_a_d   = addr[ROM_PAGE_W-1:0];
                  cnt_load  = 1'b1;
                  cnt_val   = 4'(ROM_WAIT);
               end else begin
                  ext_sel_d = 1'b1;
                  ext_a_d   = addr;
                  ext_we_d  = we;
                  ext_din_d = wdata;
                  cnt_load  = 1'b1;
                  cnt_val   = 4'(EXT_WAIT);
               end
            end
         end
         ROM: begin
            if (rom_last) begin
               rdata_d   = rom_dout;
               rom_sel_d = 1'b0;
               ack_d     = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         EXT: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (ext_rdy) begin
               if (!ext_we) rdata_d = ext_dout;
               ext_sel_d = 1'b0;
               ext_we_d  = 1'b0;
               ack_d     = 1'b1;
            end else if (tmo_hit) begin
               if (!ext_we) rdata_d = RDATA_TMO;
               err_d     = 1'b1;
               ext_sel_d = 1'b0;
               ext_we_d  = 1'b0;
               ack_d     = 1'b1;
            end else if (tmo != 8'hFF) begin
               tmo_d = tmo + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack     <= 1'b0;
         err     <= 1'b0;
         rdata   <= 8'h00;
         rom_sel <= 1'b0;
         rom_a   <= '0;
         ext_sel <= 1'b0;
         ext_a   <= 16'h0000;
         ext_we  <= 1'b0;
         ext_din <= 8'h00;
         tmo     <= 8'd0;
      end else begin
         ack     <= ack_d;
         err     <= err_d;
         rdata   <= rdata_d;
         rom_sel <= rom_sel_d;
         rom_a   <= rom_a_d;
         ext_sel <= ext_sel_d;
         ext_a   <= ext_a_d;
         ext_we  <= ext_we_d;
         ext_din <= ext_din_d;
         tmo     <= tmo_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_seq.sv
// tb/tb_mem_bus_seq.sv - self-checking bench for mem_bus_seq with ROM and external memory models
module tb_mem_bus_seq;
   import mem_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        req = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        we = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic        ack, err, rom_sel, ext_sel, ext_we, ext_rdy;
   logic [7:0]  rdata, rom_a, rom_dout, ext_din, ext_dout;
   logic [15:0] ext_a;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
      int          rdy_at;
      logic [7:0]  xdata;
      logic [7:0]  exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_sel;
   } vec_t;

   typedef struct {
      logic [7:0]  rdata;
      logic        err;
      int          lat;
      int          sel;
      int          t_acc;
      logic        chk_ext;
      logic [15:0] ea;
      logic [7:0]  ed;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int ext_cyc = 0;
   int rdy_at = 0;
   logic [7:0] ext_data = 8'h00;
   int sel_run = 0;
   int sel_len_last = 0;
   int last_ack = 0;
   int prev_ack = 0;
   int overlap = 0;

   mem_bus_seq dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .addr     (addr),
      .we       (we),
      .wdata    (wdata),
      .ack      (ack),
      .rdata    (rdata),
      .err      (err),
      .rom_sel  (rom_sel),
      .rom_a    (rom_a),
      .rom_dout (rom_dout),
      .ext_sel  (ext_sel),
      .ext_a    (ext_a),
      .ext_we   (ext_we),
      .ext_din  (ext_din),
      .ext_dout (ext_dout),
      .ext_rdy  (ext_rdy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [7:0] a);
      case (a)
         8'hFE:   return 8'hFF;
         8'h00:   return 8'h4F;
         8'h01:   return 8'h4C;
         8'h05:   return 8'h12;
         default: return a ^ 8'h3C;
      endcase
   endfunction

   assign rom_dout = rom_sel ? rom_byte(rom_a) : 8'h00;
   assign ext_dout = ext_sel ? ext_data : 8'h00;
   assign ext_rdy  = ext_sel && (rdy_at != 0) && (ext_cyc + 1 >= rdy_at);

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      ext_cyc <= ext_sel ? ext_cyc + 1 : 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (rom_sel && ext_sel) overlap++;
         if (rom_sel || ext_sel) begin
            sel_run++;
         end else if (sel_run != 0) begin
            sel_len_last = sel_run;
            sel_run = 0;
         end
         if (ack) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rdata", 32'(rdata), 32'(e.rdata));
               check("err", 32'(err), 32'(e.err));
               check("latency", 32'(cyc - e.t_acc), 32'(e.lat));
               check("sel_cycles", 32'(sel_len_last), 32'(e.sel));
               if (e.chk_ext) check("ext_write", {8'h00, ext_a, ext_din}, {8'h00, e.ea, e.ed});
               prev_ack = last_ack;
               last_ack = cyc;
            end
         end
      end else begin
         sel_run = 0;
      end
   end

   task automatic run_vec(input vec_t v);
      exp_t e;
      bit   got;
      rdy_at     = v.rdy_at;
      ext_data   = v.xdata;
      e.rdata    = v.exp_rdata;
      e.err      = v.exp_err;
      e.lat      = v.exp_lat;
      e.sel      = v.exp_sel;
      e.t_acc    = cyc;
      e.chk_ext  = v.we && (v.exp_sel != 0);
      e.ea       = v.addr;
      e.ed       = v.wdata;
      sb.push_back(e);
      sel_len_last = 0;
      addr  = v.addr;
      we    = v.we;
      wdata = v.wdata;
      req   = 1'b1;
      got   = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (ack) got = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ack_timeout: addr %0h got no ack expected ack", v.addr);
         if (sb.size() != 0) void'(sb.pop_front());
      end
      @(posedge clk);
      #1 req = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{RESET_VEC, 1'b0, 8'h00, 0, 8'h00, 8'hFF, 1'b0,  2,  1};
      vecs[1]  = '{16'hFF00,  1'b0, 8'h00, 0, 8'h00, 8'h4F, 1'b0,  2,  1};
      vecs[2]  = '{16'hFF05,  1'b0, 8'h00, 0, 8'h00, 8'h12, 1'b0,  2,  1};
      vecs[3]  = '{16'hFF10,  1'b1, 8'h55, 0, 8'h00, 8'h12, 1'b1,  1,  0};
      vecs[4]  = '{16'h0040,  1'b0, 8'h00, 4, 8'hA5, 8'hA5, 1'b0,  5,  4};
      vecs[5]  = '{16'h1234,  1'b0, 8'h00, 0, 8'h99, 8'hFF, 1'b1, 18, 17};
      vecs[6]  = '{16'h0200,  1'b1, 8'h3C, 3, 8'h00, 8'hFF, 1'b0,  4,  3};
      vecs[7]  = '{16'h0300,  1'b0, 8'h00, 1, 8'h5A, 8'h5A, 1'b0,  4,  3};
      vecs[8]  = '{16'h1000,  1'b1, 8'h77, 0, 8'h00, 8'h5A, 1'b1, 18, 17};
      vecs[9]  = '{16'hFF01,  1'b0, 8'h00, 0, 8'h00, 8'h4C, 1'b0,  2,  1};
      vecs[10] = '{16'hFF80,  1'b0, 8'h00, 0, 8'h00, 8'hBC, 1'b0,  2,  1};
      vecs[11] = '{16'hFEFF,  1'b0, 8'h00, 3, 8'h66, 8'h66, 1'b0,  4,  3};

      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", {27'd0, ack, err, rom_sel, ext_sel, ext_we}, 32'd0);
      check("reset_rdata", 32'(rdata), 32'd0);
      check("reset_addr", {8'h00, ext_a, rom_a}, 32'd0);
      check("reset_din", 32'(ext_din), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i]);
         if (i == 2) check("b2b_ack_gap", 32'(last_ack - prev_ack), 32'd3);
         if (vecs[i].exp_err) check("err_held", 32'(err), 32'd1);
      end

      // reset landing in the middle of an external access
      rdy_at   = 0;
      ext_data = 8'h00;
      addr     = 16'h2000;
      we       = 1'b0;
      req      = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("ext_sel_before_rst", 32'(ext_sel), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("rst_mid_ext_sel", 32'(ext_sel), 32'd0);
      check("rst_mid_ack", 32'(ack), 32'd0);
      check("rst_mid_rdata", 32'(rdata), 32'd0);
      req = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("idle_after_rst", {30'd0, ext_sel, rom_sel}, 32'd0);
      run_vec('{16'hFF01, 1'b0, 8'h00, 0, 8'h00, 8'h4C, 1'b0, 2, 1});

      check("sel_overlap", 32'(overlap), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
